// File: rtl/parity_pkg.sv
// Shared types for the serial parity detector.
//   par_state_t     : parity FSM state (EVEN = even number of 1s seen, ODD = odd)
//   PAR_RESET_STATE : state entered on reset (no 1s seen yet)
package parity_pkg;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } par_state_t;

  localparam par_state_t PAR_RESET_STATE = EVEN;

endpackage

// File: rtl/parity_ones_cnt.sv
// Free-running count of 1s seen on the serial input. It wraps silently at 2^CNT_W-1 -> 0.
// Ports:
//   clk   : clock, counts on rising edge
//   rst_n : asynchronous active-low reset, clears the count
//   en    : increment enable (the serial data bit)
//   cnt   : current count
module parity_ones_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/parity_gen.sv
// Serial parity detector / generator. One bit per clock on x; z is the running parity of all
// 1s sampled since reset, taken straight from the state register (Moore, 1-cycle latency).
// Parameters:
//   ODD_PARITY : 0 -> z=1 on an odd count of 1s; 1 -> z inverted (odd-parity generator bit)
//   CNT_W      : width of ones_cnt (only meaningful when PARITY_CNT_EN is defined)
// Ports:
//   x        : serial data bit, sampled on rising clk
//   clk      : clock
//   z        : parity flag
//   rst_n    : asynchronous active-low reset
//   ones_cnt : count of 1s since reset (present only when PARITY_CNT_EN is defined)
// Build option: define PARITY_CNT_EN to add the ones_cnt counter and port.
module parity_gen
  import parity_pkg::*;
#(
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             x,
  input  logic             clk,
  output logic             z,
  input  logic             rst_n
`ifdef PARITY_CNT_EN
  ,
  output logic [CNT_W-1:0] ones_cnt
`endif
);

  par_state_t state_q;
  par_state_t state_d;

  // A 1 flips the parity, a 0 leaves it alone.
  always_comb begin
    state_d = state_q;
    if (x) begin
      unique case (state_q)
        EVEN:    state_d = ODD;
        ODD:     state_d = EVEN;
        default: state_d = PAR_RESET_STATE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PAR_RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // Decoded from the state register only, so x never reaches z combinationally.
  assign z = (state_q == ODD) ^ ODD_PARITY;

`ifdef PARITY_CNT_EN
  parity_ones_cnt #(
    .CNT_W (CNT_W)
  ) u_ones_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (x),
    .cnt   (ones_cnt)
  );
`endif

endmodule

// File: tb/tb_parity_gen.sv
module tb_parity_gen;

  logic clk;
  logic rst_n;
  logic x;
  logic z0;
  logic z1;
`ifdef PARITY_CNT_EN
  logic [1:0] cnt0;
  logic [7:0] cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Detector polarity, small counter for the wrap check.
  parity_gen #(
    .ODD_PARITY (1'b0),
    .CNT_W      (2)
  ) u_dut0 (
    .x        (x),
    .clk      (clk),
    .z        (z0),
    .rst_n    (rst_n)
`ifdef PARITY_CNT_EN
    ,
    .ones_cnt (cnt0)
`endif
  );

  // Generator polarity on the same stream: z must always be the inverse.
  parity_gen #(
    .ODD_PARITY (1'b1),
    .CNT_W      (8)
  ) u_dut1 (
    .x        (x),
    .clk      (clk),
    .z        (z1),
    .rst_n    (rst_n)
`ifdef PARITY_CNT_EN
    ,
    .ones_cnt (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic x;
    logic z;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at edge+3: drive x, sample 1 unit after the next edge, return at edge+3.
  task automatic send_chk(input logic b, input logic exp_z, input string name);
    x = b;
    @(posedge clk);
    #1;
    chk({name, " z"}, {31'd0, z0}, {31'd0, exp_z});
    chk({name, " z_inv"}, {31'd0, z1}, {31'd0, ~exp_z});
    #2;
  endtask

  // Asynchronous reset pulse placed between edges (called at edge+3).
  task automatic reset_pulse(input string name);
    rst_n = 1'b0;
    #1;
    chk({name, " z"}, {31'd0, z0}, 32'd0);
    chk({name, " z_inv"}, {31'd0, z1}, 32'd1);
`ifdef PARITY_CNT_EN
    chk({name, " cnt"}, {30'd0, cnt0}, 32'd0);
`endif
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{x: 1'b0, z: 1'b0};
    vecs[1]  = '{x: 1'b1, z: 1'b1};
    vecs[2]  = '{x: 1'b1, z: 1'b0};
    vecs[3]  = '{x: 1'b1, z: 1'b1};
    vecs[4]  = '{x: 1'b0, z: 1'b1};
    vecs[5]  = '{x: 1'b1, z: 1'b0};
    vecs[6]  = '{x: 1'b1, z: 1'b1};
    vecs[7]  = '{x: 1'b0, z: 1'b1};
    vecs[8]  = '{x: 1'b0, z: 1'b1};
    vecs[9]  = '{x: 1'b1, z: 1'b0};
    vecs[10] = '{x: 1'b1, z: 1'b1};
    vecs[11] = '{x: 1'b0, z: 1'b1};

    rst_n = 1'b0;
    x     = 1'b0;

    // 1) Held in reset while x toggles: edges must be ignored.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset z", {31'd0, z0}, 32'd0);
      chk("reset z_inv", {31'd0, z1}, 32'd1);
`ifdef PARITY_CNT_EN
      chk("reset cnt", {30'd0, cnt0}, 32'd0);
      chk("reset cnt8", {24'd0, cnt1}, 32'd0);
`endif
      #2;
      x = ~x;
    end
    rst_n = 1'b1;

    // 2) Directed stream (and 5: inverse polarity checked alongside).
    for (int i = 0; i < 12; i++) begin
      send_chk(vecs[i].x, vecs[i].z, $sformatf("stream[%0d]", i));
    end

    // 4-style async clear from ODD before the zeros run.
    reset_pulse("async clr A");

    // 3) Ten zeros hold EVEN, then four ones alternate.
    for (int i = 0; i < 10; i++) send_chk(1'b0, 1'b0, $sformatf("zeros[%0d]", i));
    for (int i = 0; i < 4; i++) send_chk(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0,
                                         $sformatf("ones[%0d]", i));

    // A pulse on x that is gone before the edge must not be sampled.
    x = 1'b1;
    #4;
    x = 1'b0;
    #3;
    send_chk(1'b0, 1'b0, "glitch");

    // 4) Drive to ODD, reset between edges, then one 1 restores ODD.
    send_chk(1'b1, 1'b1, "to odd");
    reset_pulse("async clr B");
    send_chk(1'b1, 1'b1, "after clr");

    // 6) Counter wrap at CNT_W=2; z tracks cnt[0].
    reset_pulse("async clr C");
    for (int i = 0; i < 5; i++) begin
      send_chk(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, $sformatf("wrap[%0d]", i));
`ifdef PARITY_CNT_EN
      chk($sformatf("wrap cnt[%0d]", i), {30'd0, cnt0}, (i + 1) % 4);
      chk($sformatf("wrap cnt8[%0d]", i), {24'd0, cnt1}, i + 1);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
